// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   pc_src_e - next-PC source select produced by the top-level priority encoder
//   clog2    - ceiling log2 for sizing pointers and counters
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_INC,
    SRC_BR,
    SRC_RD,
    SRC_LBL,
    SRC_RM,
    SRC_RET,
    SRC_HOLD
  } pc_src_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO).
//   clk, clr     - clock, synchronous active-high clear (pointer, count, flags)
//   push, pop    - push din / pop top; callers never assert both together
//   din          - address to push
//   top          - newest entry (meaningless while empty)
//   count        - valid entries, saturates at RAS_DEPTH
//   full, empty  - decoded from registered count
//   ovf, unf     - sticky: push while full / pop while empty
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = clog2(RAS_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  din,
  output logic [PC_W-1:0]  top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int PTR_W = clog2(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] wp;  // next write slot; newest entry sits at wp-1

  assign full  = (count == CNT_W'(RAS_DEPTH));
  assign empty = (count == '0);
  assign top   = mem[wp - PTR_W'(1)];

  // Entries carry no reset: count alone says which are valid.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wp] <= din;
  end

  // Pushing while full keeps writing round the ring, so the oldest entry
  // is the one overwritten and the newest ones stay poppable.
  always_ff @(posedge clk) begin
    if (clr) begin
      wp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      wp <= wp + PTR_W'(1);
      if (full) ovf   <= 1'b1;
      else      count <= count + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        wp    <= wp - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with return-address stack.
//   clk, clr          - clock, synchronous active-high reset (beats stall)
//   stall             - hold PC and RAS, drop all requests
//   branch, disp      - PC-relative branch: pc + 1 + sext(disp)
//   jmp, flag_*_pc    - absolute jump; target rd > label > rm, none -> pc+1
//   call              - with jmp only: also push pc+1
//   ret               - pop RAS into pc; empty -> pc+1 and ras_unf
//   label, rd, rm     - jump target sources
//   pc                - registered current PC
//   ras_*             - stack occupancy and sticky error flags
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              DISP_W    = 8,
  parameter int              LABEL_W   = 11,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           stall,
  input  logic                           branch,
  input  logic [DISP_W-1:0]              disp,
  input  logic                           jmp,
  input  logic                           flag_rd_pc,
  input  logic                           flag_label_pc,
  input  logic                           flag_rm_pc,
  input  logic                           call,
  input  logic                           ret,
  input  logic [LABEL_W-1:0]             label,
  input  logic [PC_W-1:0]                rd,
  input  logic [PC_W-1:0]                rm,
  output logic [PC_W-1:0]                pc,
  output logic [clog2(RAS_DEPTH):0]      ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  pc_src_e         sel;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] ras_top;
  logic            push;
  logic            pop;

  assign pc_inc = pc + PC_W'(1);

  // Priority: stall > ret > jmp > branch > increment (clr handled at the register).
  always_comb begin
    sel  = SRC_INC;
    push = 1'b0;
    pop  = 1'b0;
    if (stall) begin
      sel = SRC_HOLD;
    end else if (ret) begin
      sel = SRC_RET;
      pop = 1'b1;
    end else if (jmp) begin
      if      (flag_rd_pc)    sel = SRC_RD;
      else if (flag_label_pc) sel = SRC_LBL;
      else if (flag_rm_pc)    sel = SRC_RM;
      push = call;
    end else if (branch) begin
      sel = SRC_BR;
    end
  end

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      SRC_BR:   pc_next = pc_inc + PC_W'($signed(disp));
      SRC_RD:   pc_next = rd;
      SRC_LBL:  pc_next = PC_W'(label);
      SRC_RM:   pc_next = rm;
      // Return from an empty stack falls through to the next instruction.
      SRC_RET:  pc_next = ras_empty ? pc_inc : ras_top;
      SRC_HOLD: pc_next = pc;
      default:  pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clr, stall, branch, jmp, call, ret;
  logic        flag_rd_pc, flag_label_pc, flag_rm_pc;
  logic [7:0]  disp;
  logic [10:0] label;
  logic [15:0] rd, rm, pc;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .clr(clr), .stall(stall), .branch(branch), .disp(disp),
    .jmp(jmp), .flag_rd_pc(flag_rd_pc), .flag_label_pc(flag_label_pc),
    .flag_rm_pc(flag_rm_pc), .call(call), .ret(ret), .label(label),
    .rd(rd), .rm(rm), .pc(pc), .ras_count(ras_count), .ras_full(ras_full),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clr = 0; stall = 0; branch = 0; jmp = 0; call = 0; ret = 0;
    flag_rd_pc = 0; flag_label_pc = 0; flag_rm_pc = 0;
    disp = '0; label = '0; rd = '0; rm = '0;
  endtask

  // One edge, then settle; inputs change only after this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [15:0] tgt);
    idle(); jmp = 1; call = 1; flag_rd_pc = 1; rd = tgt; step();
  endtask

  task automatic do_ret();
    idle(); ret = 1; step();
  endtask

  initial begin
    idle();
    // 1 reset
    clr = 1;
    repeat (5) step();
    chk("rst_pc", pc, 16'd0);
    chk("rst_empty", ras_empty, 1);
    chk("rst_full", ras_full, 0);
    chk("rst_count", ras_count, 0);
    chk("rst_ovf", ras_ovf, 0);
    chk("rst_unf", ras_unf, 0);
    idle(); step(); chk("inc1", pc, 16'd1);
    step(); chk("inc2", pc, 16'd2);
    step(); chk("inc3", pc, 16'd3);

    // 2 branch
    branch = 1; disp = 8'd5; step(); chk("br_fwd", pc, 16'd9);
    disp = 8'hFD; step(); chk("br_back", pc, 16'd7);
    idle(); clr = 1; step(); idle();
    branch = 1; disp = 8'h80; step(); chk("br_min", pc, 16'hFF81);

    // 3 jumps
    idle(); jmp = 1; flag_rd_pc = 1; rd = 16'd20; step(); chk("jmp_rd", pc, 16'd20);
    idle(); jmp = 1; flag_label_pc = 1; label = 11'd15; rd = 16'd99; step(); chk("jmp_lbl", pc, 16'd15);
    idle(); jmp = 1; flag_rm_pc = 1; rm = 16'd50; step(); chk("jmp_rm", pc, 16'd50);
    idle(); jmp = 1; flag_rd_pc = 1; flag_label_pc = 1; flag_rm_pc = 1;
    rd = 16'd20; label = 11'd15; rm = 16'd50; step(); chk("jmp_prio", pc, 16'd20);
    idle(); jmp = 1; flag_label_pc = 1; flag_rm_pc = 1; label = 11'h7FF; rm = 16'd50;
    step(); chk("jmp_lbl_zext", pc, 16'h07FF);
    idle(); jmp = 1; rd = 16'd300; step(); chk("jmp_noflag", pc, 16'h0800);

    // 4 call/ret
    idle(); jmp = 1; flag_rd_pc = 1; rd = 16'd5; step();
    do_call(16'd100);
    chk("call_pc", pc, 16'd100);
    chk("call_cnt", ras_count, 1);
    do_ret();
    chk("ret_pc", pc, 16'd6);
    chk("ret_empty", ras_empty, 1);
    chk("ret_unf0", ras_unf, 0);
    do_ret();
    chk("unf_pc", pc, 16'd7);
    chk("unf_flag", ras_unf, 1);
    chk("unf_cnt", ras_count, 0);
    idle(); call = 1; flag_rd_pc = 1; rd = 16'd77; step();
    chk("call_nojmp_pc", pc, 16'd8);
    chk("call_nojmp_cnt", ras_count, 0);
    do_call(16'd30);                       // push 9
    idle(); ret = 1; jmp = 1; call = 1; flag_rd_pc = 1; rd = 16'd60; branch = 1; disp = 8'd4;
    step();
    chk("ret_wins_pc", pc, 16'd9);
    chk("ret_wins_cnt", ras_count, 0);

    // 5 overflow
    idle(); clr = 1; step();
    do_call(16'd100);                      // push 1
    do_call(16'd200);                      // push 101
    do_call(16'd300);                      // push 201
    do_call(16'd400);                      // push 301
    chk("full4", ras_full, 1);
    chk("ovf_pre", ras_ovf, 0);
    do_call(16'd500);                      // push 401, drops 1
    chk("ovf_pc", pc, 16'd500);
    chk("ovf_flag", ras_ovf, 1);
    chk("ovf_cnt", ras_count, 4);
    do_ret(); chk("pop401", pc, 16'd401);
    do_ret(); chk("pop301", pc, 16'd301);
    do_ret(); chk("pop201", pc, 16'd201);
    do_ret(); chk("pop101", pc, 16'd101);
    chk("ovf_empty", ras_empty, 1);
    do_ret();
    chk("lost_pc", pc, 16'd102);
    chk("lost_unf", ras_unf, 1);

    // 6 stall / wrap / clr mid-stall
    idle(); stall = 1; branch = 1; disp = 8'd5;
    step(); chk("stall1", pc, 16'd102);
    step(); chk("stall2", pc, 16'd102);
    step(); chk("stall3", pc, 16'd102);
    idle(); jmp = 1; flag_rd_pc = 1; rd = 16'hFFFF; step(); chk("to_ffff", pc, 16'hFFFF);
    idle(); step(); chk("wrap_inc", pc, 16'd0);
    idle(); jmp = 1; flag_rd_pc = 1; rd = 16'hFFFE; step();
    idle(); branch = 1; disp = 8'd2; step(); chk("wrap_br", pc, 16'd1);
    do_call(16'd40);
    idle(); stall = 1; ret = 1; step();
    chk("stall_ret_pc", pc, 16'd40);
    chk("stall_ret_cnt", ras_count, 1);
    idle(); stall = 1; clr = 1; step();
    chk("clr_stall_pc", pc, 16'd0);
    chk("clr_stall_cnt", ras_count, 0);
    chk("clr_stall_unf", ras_unf, 0);
    chk("clr_stall_ovf", ras_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
